// File: rtl/aes_pkg.sv
// Shared AES datapath types and constants for the result path.
package aes_pkg;
  typedef logic [1:0] engine_id_t;

  localparam int AES_BLOCK_W         = 128;
  localparam int AES_WORD_W          = 32;
  localparam int AES_WORDS_PER_BLOCK = 4;
  localparam int AES_NUM_ENGINES     = 3;

  typedef enum logic {IDLE, SEND} ser_state_t;
endpackage

// File: rtl/aes_order_fifo.sv
// Dispatch-order queue of engine ids; push into a full queue succeeds only alongside a pop.
module aes_order_fifo
  import aes_pkg::*;
#(
  parameter int ORDER_DEPTH = 4
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       push,
  input  engine_id_t push_id,
  input  logic       pop,
  output engine_id_t head,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(ORDER_DEPTH);

  engine_id_t      mem [ORDER_DEPTH];
  logic [AW:0]     wr_ptr, rd_ptr;
  logic            do_push, do_pop;

  // Extra pointer bit distinguishes full from empty when indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_id;
  end
endmodule

// File: rtl/aes_result_collector.sv
// Captures AES engine results, restores dispatch order and streams each block as four 32-bit words.
module aes_result_collector
  import aes_pkg::*;
#(
  parameter int ORDER_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   enable1,
  input  logic                   enable2,
  input  logic                   enable3,
  input  logic                   ready1,
  input  logic                   ready2,
  input  logic                   ready3,
  input  logic [AES_BLOCK_W-1:0] result1,
  input  logic [AES_BLOCK_W-1:0] result2,
  input  logic [AES_BLOCK_W-1:0] result3,
  output logic [AES_WORD_W-1:0]  out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic                   overflow,
  output logic                   order_err,
  output logic                   idle
);
  localparam int NE = AES_NUM_ENGINES;

  logic [NE-1:0]                  en, en_q, dsp_edge, rdy, slot_full, head_oh;
  logic [NE-1:0][AES_BLOCK_W-1:0] res, slot;
  logic [AES_BLOCK_W-1:0]         shreg, load_data;
  logic [1:0]                     idx;
  ser_state_t                     state;
  engine_id_t                     push_id, head;
  logic                           push, load, q_full, q_empty, multi_edge;

  assign en         = {enable3, enable2, enable1};
  assign rdy        = {ready3, ready2, ready1};
  assign res        = {result3, result2, result1};
  assign dsp_edge   = en & ~en_q;
  assign push       = |dsp_edge;
  assign multi_edge = ($countones(dsp_edge) > 1);

  // Lowest engine wins when several edges collide.
  always_comb begin
    push_id = '0;
    for (int i = NE - 1; i >= 0; i--)
      if (dsp_edge[i]) push_id = engine_id_t'(i + 1);
  end

  always_comb begin
    head_oh   = '0;
    load_data = '0;
    for (int i = 0; i < NE; i++) begin
      head_oh[i] = (head == engine_id_t'(i + 1));
      if (head == engine_id_t'(i + 1)) load_data = load_data | slot[i];
    end
  end

  // Only the queue head may load; a head whose slot is empty blocks everything behind it.
  assign load = (state == IDLE) && !q_empty && |(head_oh & slot_full);

  aes_order_fifo #(.ORDER_DEPTH(ORDER_DEPTH)) u_order (
    .clk     (clk),
    .n_rst   (n_rst),
    .push    (push),
    .push_id (push_id),
    .pop     (load),
    .head    (head),
    .full    (q_full),
    .empty   (q_empty)
  );

  // A completion into an occupied slot is dropped even if that slot is unloading now.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      slot_full <= '0;
      slot      <= '0;
    end else begin
      for (int i = 0; i < NE; i++) begin
        if (rdy[i] && !slot_full[i]) begin
          slot[i]      <= res[i];
          slot_full[i] <= 1'b1;
        end else if (load && head_oh[i]) begin
          slot_full[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      en_q      <= '0;
      overflow  <= 1'b0;
      order_err <= 1'b0;
    end else begin
      en_q <= en;
      if (|(rdy & slot_full)) overflow <= 1'b1;
      if (multi_edge || (push && q_full && !load)) order_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= IDLE;
      shreg     <= '0;
      idx       <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (load) begin
          state     <= SEND;
          shreg     <= load_data;
          idx       <= '0;
          out_valid <= 1'b1;
          out_last  <= 1'b0;
        end
        SEND: if (out_ready) begin
          shreg    <= shreg << AES_WORD_W;
          idx      <= idx + 2'd1;
          out_last <= (idx == 2'(AES_WORDS_PER_BLOCK - 2));
          if (idx == 2'(AES_WORDS_PER_BLOCK - 1)) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign out_data = shreg[AES_BLOCK_W-1 -: AES_WORD_W];
  assign idle     = q_empty && !(|slot_full) && (state == IDLE);
endmodule

// File: tb/tb_aes_result_collector.sv
// Bench for aes_result_collector: vector table, directed corner sequences and a randomized scoreboard run.
module tb_aes_result_collector;
  logic         clk = 1'b0;
  logic         n_rst;
  logic [3:1]   en, rdy;
  logic [127:0] res [1:3];
  logic [31:0]  out_data;
  logic         out_valid, out_ready, out_last, overflow, order_err, idle;
  int           tests = 0, fails = 0;

  typedef struct {
    int                eng;
    logic [127:0]      blk;
    logic [0:3][31:0]  w;
  } vec_t;
  vec_t tbl [4];

  logic [127:0] exp_q [$];
  int           id_q [$];
  bit           busy [1:3];
  bit           pend [1:3];
  logic [127:0] blk [1:3];
  bit           mon_en = 1'b0;
  int           widx = 0;
  int           mon_id;

  always #5 clk = ~clk;

  aes_result_collector #(.ORDER_DEPTH(4)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .enable1   (en[1]),
    .enable2   (en[2]),
    .enable3   (en[3]),
    .ready1    (rdy[1]),
    .ready2    (rdy[2]),
    .ready3    (rdy[3]),
    .result1   (res[1]),
    .result2   (res[2]),
    .result3   (res[3]),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .overflow  (overflow),
    .order_err (order_err),
    .idle      (idle)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dispatch(input int e);
    en[e] = 1'b1;
    tick();
    en[e] = 1'b0;
  endtask

  task automatic complete(input int e, input logic [127:0] d);
    res[e] = d;
    rdy[e] = 1'b1;
    tick();
    rdy[e] = 1'b0;
  endtask

  task automatic do_reset();
    n_rst = 1'b0; en = '0; rdy = '0; out_ready = 1'b0;
    tick();
    n_rst = 1'b1;
    tick();
  endtask

  task automatic collect_block(input string nm, input logic [127:0] b);
    int n;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (!(out_valid && out_ready) && n < 40) begin tick(); n++; end
      chk({nm, "_valid"}, 128'(out_valid), 128'(1));
      chk({nm, "_data"},  128'(out_data),  128'(b[127-32*k -: 32]));
      chk({nm, "_last"},  128'(out_last),  128'(k == 3));
      tick();
    end
  endtask

  // Scoreboard: every accepted word must match the oldest dispatched block, in dispatch order.
  always @(negedge clk) begin
    if (mon_en && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("rnd_spurious", 128'(out_valid), 128'(0));
      else begin
        chk("rnd_data", 128'(out_data), 128'(exp_q[0][127-32*widx -: 32]));
        chk("rnd_last", 128'(out_last), 128'(widx == 3));
        widx++;
        if (widx == 4) begin
          widx = 0;
          void'(exp_q.pop_front());
          mon_id = id_q.pop_front();
          busy[mon_id] = 1'b0;
        end
      end
    end
  end

  initial begin
    int e;
    tbl[0] = '{eng: 1, blk: 128'h00112233_44556677_8899AABB_CCDDEEFF,
               w: {32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF}};
    tbl[1] = '{eng: 2, blk: 128'hDEADBEEF_01234567_89ABCDEF_FEDCBA98,
               w: {32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98}};
    tbl[2] = '{eng: 3, blk: 128'hFFFFFFFF_00000000_A5A5A5A5_5A5A5A5A,
               w: {32'hFFFFFFFF, 32'h00000000, 32'hA5A5A5A5, 32'h5A5A5A5A}};
    tbl[3] = '{eng: 1, blk: 128'h00000001_00000000_00000000_80000000,
               w: {32'h00000001, 32'h00000000, 32'h00000000, 32'h80000000}};
    for (int k = 1; k <= 3; k++) begin res[k] = '0; busy[k] = 1'b0; pend[k] = 1'b0; end

    n_rst = 1'b0; en = '0; rdy = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data",  128'(out_data),  128'(0));
    chk("rst_valid", 128'(out_valid), 128'(0));
    chk("rst_last",  128'(out_last),  128'(0));
    chk("rst_ovf",   128'(overflow),  128'(0));
    chk("rst_oerr",  128'(order_err), 128'(0));
    chk("rst_idle",  128'(idle),      128'(1));
    n_rst = 1'b1;
    tick();

    // Table: single blocks, first word exactly two cycles after ready.
    out_ready = 1'b1;
    for (int v = 0; v < 4; v++) begin
      dispatch(tbl[v].eng);
      complete(tbl[v].eng, tbl[v].blk);
      chk("tbl_lat", 128'(out_valid), 128'(0));
      tick();
      for (int k = 0; k < 4; k++) begin
        chk("tbl_valid", 128'(out_valid), 128'(1));
        chk("tbl_data",  128'(out_data),  128'(tbl[v].w[k]));
        chk("tbl_last",  128'(out_last),  128'(k == 3));
        tick();
      end
      chk("tbl_end", 128'(out_valid), 128'(0));
    end

    // Reordering: complete 3,2,1 -> emitted in dispatch order 1,2,3.
    dispatch(1); dispatch(2); dispatch(3);
    complete(3, 128'hAAAAAAAA_11111111_22222222_33333333);
    complete(2, 128'hBBBBBBBB_44444444_55555555_66666666);
    complete(1, 128'hCCCCCCCC_77777777_88888888_99999999);
    collect_block("ord_c", 128'hCCCCCCCC_77777777_88888888_99999999);
    collect_block("ord_b", 128'hBBBBBBBB_44444444_55555555_66666666);
    collect_block("ord_a", 128'hAAAAAAAA_11111111_22222222_33333333);

    // Backpressure at word 2.
    dispatch(2);
    complete(2, 128'h10203040_50607080_90A0B0C0_D0E0F000);
    tick();
    chk("bp_w0", 128'(out_data), 128'(32'h10203040)); tick();
    chk("bp_w1", 128'(out_data), 128'(32'h50607080)); tick();
    chk("bp_w2", 128'(out_data), 128'(32'h90A0B0C0));
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("bp_hold_data",  128'(out_data),  128'(32'h90A0B0C0));
      chk("bp_hold_last",  128'(out_last),  128'(0));
      chk("bp_hold_valid", 128'(out_valid), 128'(1));
    end
    out_ready = 1'b1;
    tick();
    chk("bp_w3",   128'(out_data), 128'(32'hD0E0F000));
    chk("bp_last", 128'(out_last), 128'(1));
    tick();
    chk("bp_end", 128'(out_valid), 128'(0));

    // Randomized traffic against an in-order block scoreboard.
    do_reset();
    mon_en = 1'b1;
    for (int c = 0; c < 800; c++) begin
      en = '0; rdy = '0;
      out_ready = ($urandom_range(3) != 0);
      e = int'($urandom_range(3, 1));
      if (pend[e] && $urandom_range(1) == 1) begin
        res[e] = blk[e]; rdy[e] = 1'b1; pend[e] = 1'b0;
      end
      e = int'($urandom_range(3, 1));
      if (!busy[e] && $urandom_range(2) == 0) begin
        blk[e] = {$urandom, $urandom, $urandom, $urandom};
        busy[e] = 1'b1; pend[e] = 1'b1; en[e] = 1'b1;
        exp_q.push_back(blk[e]);
        id_q.push_back(e);
      end
      tick();
    end
    for (int c = 0; c < 400 && exp_q.size() != 0; c++) begin
      en = '0; rdy = '0; out_ready = 1'b1;
      for (int k = 1; k <= 3; k++)
        if (pend[k]) begin res[k] = blk[k]; rdy[k] = 1'b1; pend[k] = 1'b0; end
      tick();
    end
    rdy = '0;
    tick();
    mon_en = 1'b0;
    chk("rnd_drained", 128'(exp_q.size()), 128'(0));
    chk("rnd_idle",    128'(idle),         128'(1));
    chk("rnd_ovf",     128'(overflow),     128'(0));
    chk("rnd_oerr",    128'(order_err),    128'(0));

    // Overflow: second ready2 while slot 2 waits behind head engine 1.
    do_reset();
    dispatch(1); dispatch(2);
    complete(2, 128'hE0E0E0E0_E1E1E1E1_E2E2E2E2_E3E3E3E3);
    chk("ovf_pre", 128'(overflow), 128'(0));
    complete(2, 128'hF0F0F0F0_F1F1F1F1_F2F2F2F2_F3F3F3F3);
    chk("ovf_set", 128'(overflow), 128'(1));
    complete(1, 128'h12345678_9ABCDEF0_0FEDCBA9_87654321);
    out_ready = 1'b1;
    collect_block("ovf_g", 128'h12345678_9ABCDEF0_0FEDCBA9_87654321);
    collect_block("ovf_e", 128'hE0E0E0E0_E1E1E1E1_E2E2E2E2_E3E3E3E3);
    for (int c = 0; c < 10; c++) begin
      chk("ovf_no_f", 128'(out_valid), 128'(0));
      tick();
    end
    chk("ovf_idle",   128'(idle),     128'(1));
    chk("ovf_sticky", 128'(overflow), 128'(1));

    // Queue full: ids 1,2,3,1 kept, fifth (2) discarded.
    do_reset();
    dispatch(1); dispatch(2); dispatch(3); dispatch(1);
    chk("qf_pre", 128'(order_err), 128'(0));
    dispatch(2);
    chk("qf_err", 128'(order_err), 128'(1));
    out_ready = 1'b1;
    complete(1, 128'hA1A1A1A1_A2A2A2A2_A3A3A3A3_A4A4A4A4);
    collect_block("qf_1", 128'hA1A1A1A1_A2A2A2A2_A3A3A3A3_A4A4A4A4);
    complete(2, 128'hB1B1B1B1_B2B2B2B2_B3B3B3B3_B4B4B4B4);
    collect_block("qf_2", 128'hB1B1B1B1_B2B2B2B2_B3B3B3B3_B4B4B4B4);
    complete(3, 128'hC1C1C1C1_C2C2C2C2_C3C3C3C3_C4C4C4C4);
    collect_block("qf_3", 128'hC1C1C1C1_C2C2C2C2_C3C3C3C3_C4C4C4C4);
    complete(1, 128'hD1D1D1D1_D2D2D2D2_D3D3D3D3_D4D4D4D4);
    collect_block("qf_4", 128'hD1D1D1D1_D2D2D2D2_D3D3D3D3_D4D4D4D4);
    complete(2, 128'h55555555_66666666_77777777_88888888);
    for (int c = 0; c < 8; c++) begin
      chk("qf_dropped", 128'(out_valid), 128'(0));
      tick();
    end
    chk("qf_slot_held", 128'(idle), 128'(0));

    // Two edges in one cycle: only engine 1 queued, order_err set.
    do_reset();
    en = 3'b101;
    tick();
    en = '0;
    chk("me_err", 128'(order_err), 128'(1));
    complete(3, 128'h33333333_33333333_33333333_33333333);
    complete(1, 128'h01010101_02020202_03030303_04040404);
    out_ready = 1'b1;
    collect_block("me_1", 128'h01010101_02020202_03030303_04040404);
    for (int c = 0; c < 8; c++) begin
      chk("me_no3", 128'(out_valid), 128'(0));
      tick();
    end

    // Reset mid-block during word 1.
    do_reset();
    out_ready = 1'b1;
    dispatch(3);
    complete(3, 128'h9999AAAA_BBBBCCCC_DDDDEEEE_FFFF0000);
    tick();
    tick();
    chk("mr_w1", 128'(out_data), 128'(32'hBBBBCCCC));
    n_rst = 1'b0;
    #1;
    chk("mr_valid", 128'(out_valid), 128'(0));
    chk("mr_idle",  128'(idle),      128'(1));
    chk("mr_data",  128'(out_data),  128'(0));
    @(negedge clk);
    n_rst = 1'b1;
    tick();
    dispatch(1);
    complete(1, 128'h0BADF00D_CAFEBABE_13579BDF_2468ACE0);
    collect_block("mr_fresh", 128'h0BADF00D_CAFEBABE_13579BDF_2468ACE0);
    chk("mr_oerr", 128'(order_err), 128'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/aes_result_collector.md
# aes_result_collector

- Sits directly downstream of the three AES encrypt engines and alongside the AES dispatch controller.
- Captures each engine's 128-bit result when the engine signals completion, then restores the original dispatch order. Dispatch order is learned from rising edges of the controller's per-engine enables.
- Streams each result out as four 32-bit words over a valid/ready handshake.
- Flags result loss with sticky error bits.

## Interface
Parameters:
- ORDER_DEPTH, 4: entries in the dispatch-order queue; power of two, ≥ 3.

Ports:
- clk  in  1  system clock; all state on rising edge.
- n_rst  in  1  asynchronous active-low reset.
- enable1, enable2, enable3  in  1 each  controller engine enables; a 0→1 transition marks a dispatch to that engine.
- ready1, ready2, ready3  in  1 each  one-cycle completion pulse from engine n; data valid in the same cycle.
- result1, result2, result3  in  128 each  engine result buses.
- out_data  out  32  current output word.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts the word when out_valid && out_ready.
- out_last  out  1  high with the fourth word of a block.
- overflow  out  1  sticky: a result was dropped.
- order_err  out  1  sticky: a dispatch was seen while the order queue was full.
- idle  out  1  order queue empty, all slots empty, serializer idle.

Reset values: out_data 0, out_valid 0, out_last 0, overflow 0, order_err 0, idle 1.

## Operation
Edge detection:
- Registered copies of enable1..3 reset to 0.
- A dispatch of engine n is detected in the cycle where enable_n = 1 and its registered copy = 0.
- The controller activates at most one engine per cycle. If more than one edge appears in a cycle, push the lowest engine id only and set order_err.

Order queue:
- FIFO of 2-bit engine ids (1..3), ORDER_DEPTH entries.
- Push on a detected dispatch; pop when the serializer loads.
- Simultaneous push and pop is allowed at any occupancy, including full.
- Push into a full queue with no pop: the id is discarded and order_err is set.

Result slots:
- One 128-bit slot plus a full bit per engine.
- ready_n with slot n empty: capture result_n and set full.
- ready_n with slot n full: data discarded, overflow set. This stands even if the serializer empties slot n in the same cycle, so no bypass path is needed.

Serializer FSM:
- IDLE: if the queue is non-empty and the slot named by the head is full, load the 128-bit shift register from that slot, clear the slot's full bit, pop the queue, and go to SEND with word index 0. Otherwise stay in IDLE.
- SEND:
  - out_valid = 1; out_data = the current word, most-significant word (bits 127:96) first.
  - out_last = 1 when word index = 3.
  - On a handshake: advance the index. After the word-3 handshake, go to IDLE.
  - Without a handshake: out_data and out_last hold stable.
- A head entry whose slot is empty blocks output, even if other slots are full. In-order delivery is mandatory.

Error flags:
- overflow and order_err clear only on reset.

## Timing
- ready_n pulse at cycle T → slot full at T+1.
- Serializer in IDLE at T+1 loads at T+1 → first word out_valid at T+2. Minimum completion-to-first-word latency is 2 cycles.
- With out_ready held high, a block takes 4 SEND cycles + 1 IDLE cycle, so throughput is 5 cycles per block.
- Reset is asynchronous and may assert mid-block. All slots, queue pointers, the FSM and the flags clear immediately, and the partial block is abandoned.
- idle is combinational from registered state.

## Structure
Shared package aes_pkg holds:
- typedef engine_id_t (logic [1:0]);
- constants AES_BLOCK_W = 128, AES_WORD_W = 32, AES_WORDS_PER_BLOCK = 4;
- serializer state enum (IDLE, SEND).

Sub-module:
- The order queue is one natural sub-module: aes_order_fifo, with push/pop/full/empty and a head output, parameterised by ORDER_DEPTH.

## Test plan
- Single block: dispatch engine 1; ready1 with result1 = 0x00112233_44556677_8899AABB_CCDDEEFF; out_ready = 1 → words 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF on consecutive cycles starting 2 cycles after ready1, with out_last on the 4th.
- Reordering: dispatch 1, 2, 3 in consecutive cycles; complete in order 3, 2, 1 with results A, B, C → output order C, B, A (engine 1's result first).
- Backpressure: out_ready low for 5 cycles mid-block at word 2 → out_data and out_last remain stable, and no word is lost or duplicated.
- Overflow: engine 2 result captured and out_ready held low; a second ready2 arrives → overflow = 1, the first result is still emitted intact, the second result never appears, and overflow stays 1.
- Queue full: ORDER_DEPTH = 4; five dispatches with no completions → order_err = 1 after the fifth edge, and the first four ids are retained.
- Reset mid-block: assert n_rst low during word 1 → out_valid = 0 and idle = 1 immediately. After release, a fresh block streams correctly.
